// File: rtl/sl_preceptron_mem_arb.sv
// Two-requester single-port RAM arbiter: host vs perceptron engine, with
// round-robin tie-break and bounded locked bursts.
module sl_preceptron_mem_arb #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic                  h_lock,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic                  e_lock,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_wdata,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned       BCNT_W   = 8;
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BURST);
    localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_H = 2'd1,
        ST_OWN_E = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_rr;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_h_rvalid;
    logic              r_e_rvalid;

    state_t            w_state_nxt;
    logic              w_rr_nxt;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic [BCNT_W-1:0] w_bcnt_inc;
    logic              w_h_gnt;
    logic              w_e_gnt;

    // Grant decision and next-state; grants are forced low while in reset
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_bcnt_nxt  = r_bcnt;
        w_h_gnt     = 1'b0;
        w_e_gnt     = 1'b0;
        w_bcnt_inc  = (r_bcnt >= BCNT_MAX) ? BCNT_MAX : r_bcnt + BCNT_ONE;

        case (r_state)
            ST_IDLE: begin
                if (h_req && (!e_req || !r_rr)) begin
                    w_h_gnt = 1'b1;
                    if (e_req) w_rr_nxt = 1'b1;
                    if (h_lock) begin
                        w_state_nxt = ST_OWN_H;
                        w_bcnt_nxt  = BCNT_ONE;
                    end
                end else if (e_req) begin
                    w_e_gnt = 1'b1;
                    if (h_req) w_rr_nxt = 1'b0;
                    if (e_lock) begin
                        w_state_nxt = ST_OWN_E;
                        w_bcnt_nxt  = BCNT_ONE;
                    end
                end
            end
            ST_OWN_H: begin
                // A saturated burst yields as soon as the engine asks
                if ((r_bcnt == BCNT_MAX) && e_req) begin
                    w_e_gnt     = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = 1'b1;
                    w_bcnt_nxt  = '0;
                end else if (h_req) begin
                    w_h_gnt    = 1'b1;
                    w_bcnt_nxt = w_bcnt_inc;
                    if (!h_lock || ((w_bcnt_inc == BCNT_MAX) && e_req)) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = 1'b1;
                        w_bcnt_nxt  = '0;
                    end
                end else begin
                    w_e_gnt     = e_req;
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = 1'b1;
                    w_bcnt_nxt  = '0;
                end
            end
            ST_OWN_E: begin
                if ((r_bcnt == BCNT_MAX) && h_req) begin
                    w_h_gnt     = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = 1'b0;
                    w_bcnt_nxt  = '0;
                end else if (e_req) begin
                    w_e_gnt    = 1'b1;
                    w_bcnt_nxt = w_bcnt_inc;
                    if (!e_lock || ((w_bcnt_inc == BCNT_MAX) && h_req)) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = 1'b0;
                        w_bcnt_nxt  = '0;
                    end
                end else begin
                    w_h_gnt     = h_req;
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = 1'b0;
                    w_bcnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_bcnt_nxt  = '0;
            end
        endcase

        if (!rst_n) begin
            w_h_gnt = 1'b0;
            w_e_gnt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr       <= 1'b0;
            r_bcnt     <= '0;
            r_h_rvalid <= 1'b0;
            r_e_rvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_h_rvalid <= w_h_gnt & ~h_we;
            r_e_rvalid <= w_e_gnt & ~e_we;
        end
    end

    // RAM port steering from whichever side holds the grant
    always_comb begin
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_h_gnt) begin
            mem_wen   = h_we;
            mem_ren   = ~h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (w_e_gnt) begin
            mem_wen   = e_we;
            mem_ren   = ~e_we;
            mem_addr  = e_addr;
            mem_wdata = e_wdata;
        end
    end

    assign h_gnt    = w_h_gnt;
    assign e_gnt    = w_e_gnt;
    assign h_rvalid = r_h_rvalid;
    assign e_rvalid = r_e_rvalid;
    assign rdata    = mem_rdata;

endmodule

// File: tb/tb_sl_preceptron_mem_arb.sv
// Bench for sl_preceptron_mem_arb: directed scenarios plus a randomized run
// against an ownership-based reference model and a behavioural RAM.
module tb_sl_preceptron_mem_arb;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned MB = 4;

    logic          clk;
    logic          rst_n;
    logic          h_req, h_we, h_lock, e_req, e_we, e_lock;
    logic [AW-1:0] h_addr, e_addr, mem_addr;
    logic [DW-1:0] h_wdata, e_wdata, mem_wdata, rdata, mem_rdata;
    logic          h_gnt, h_rvalid, e_gnt, e_rvalid, mem_wen, mem_ren;

    int n_tests = 0;
    int n_fail  = 0;

    sl_preceptron_mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid),
        .rdata(rdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: write on mem_wen, registered read data one cycle after mem_ren
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    // Reference model: who owns the RAM, how long, and whose turn it is
    int            m_owner;   // 0 none, 1 host, 2 engine
    int            m_burst;
    bit            m_rr;      // 1 = engine has priority on a tie
    bit            m_hrv, m_erv, m_rexpv;
    logic [DW-1:0] m_rexp;
    logic [DW-1:0] m_ram  [0:(1<<AW)-1];
    bit            m_ramv [0:(1<<AW)-1];

    task automatic model_reset();
        m_owner = 0; m_burst = 0; m_rr = 1'b0;
        m_hrv = 1'b0; m_erv = 1'b0; m_rexpv = 1'b0; m_rexp = '0;
        for (int i = 0; i < (1<<AW); i++) m_ramv[i] = 1'b0;
    endtask

    task automatic model_predict(output bit gh, output bit ge);
        gh = 1'b0; ge = 1'b0;
        if (m_owner == 0) begin
            if (h_req && e_req) begin gh = !m_rr; ge = m_rr; end
            else begin gh = h_req; ge = e_req; end
        end else if (m_owner == 1) begin
            if (m_burst == MB && e_req) ge = 1'b1;
            else if (h_req)             gh = 1'b1;
            else                        ge = e_req;
        end else begin
            if (m_burst == MB && h_req) gh = 1'b1;
            else if (e_req)             ge = 1'b1;
            else                        gh = h_req;
        end
    endtask

    task automatic model_commit(input bit gh, input bit ge);
        m_hrv = gh && !h_we;
        m_erv = ge && !e_we;
        if (m_hrv) begin m_rexp = m_ram[h_addr]; m_rexpv = m_ramv[h_addr]; end
        if (m_erv) begin m_rexp = m_ram[e_addr]; m_rexpv = m_ramv[e_addr]; end
        if (gh && h_we) begin m_ram[h_addr] = h_wdata; m_ramv[h_addr] = 1'b1; end
        if (ge && e_we) begin m_ram[e_addr] = e_wdata; m_ramv[e_addr] = 1'b1; end
        if (m_owner == 0) begin
            if (h_req && e_req) m_rr = gh;
            if (gh && h_lock) begin m_owner = 1; m_burst = 1; end
            if (ge && e_lock) begin m_owner = 2; m_burst = 1; end
        end else if (m_owner == 1) begin
            if (gh) begin
                m_burst = (m_burst < MB) ? m_burst + 1 : MB;
                if (!h_lock || (m_burst == MB && e_req)) begin m_owner = 0; m_rr = 1'b1; end
            end else begin
                m_owner = 0; m_rr = 1'b1;
            end
        end else begin
            if (ge) begin
                m_burst = (m_burst < MB) ? m_burst + 1 : MB;
                if (!e_lock || (m_burst == MB && h_req)) begin m_owner = 0; m_rr = 1'b0; end
            end else begin
                m_owner = 0; m_rr = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit hr, input bit hw, input bit hl, input logic [AW-1:0] ha,
                         input logic [DW-1:0] hd, input bit er, input bit ew, input bit el,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        h_req = hr; h_we = hw; h_lock = hl; h_addr = ha; h_wdata = hd;
        e_req = er; e_we = ew; e_lock = el; e_addr = ea; e_wdata = ed;
    endtask

    task automatic idle_inputs();
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // Sample point mid-cycle; the mutual-exclusion properties hold every cycle
    task automatic settle();
        @(negedge clk);
        n_tests++;
        if ((h_gnt && e_gnt) || (mem_wen && mem_ren)) begin
            n_fail++;
            $display("FAIL exclusivity t=%0t got gnt h/e=%b%b wen/ren=%b%b, need no pair both 1",
                     $time, h_gnt, e_gnt, mem_wen, mem_ren);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 0, 6'd1, '0, 1, 0, 0, 6'd2, '0);
        #2;
        n_tests++;
        if ({h_gnt, e_gnt, mem_wen, mem_ren, h_rvalid, e_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b need 000000",
                     {h_gnt, e_gnt, mem_wen, mem_ren, h_rvalid, e_rvalid});
        end
        tick();
        rst_n = 1'b1;
        settle();
        n_tests++;
        if ({h_gnt, e_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_grant got h/e=%b%b need 10", h_gnt, e_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_write_read();
        drive(1, 1, 0, 6'd3, 8'hA5, 0, 0, 0, '0, '0);
        settle();
        n_tests++;
        if ({h_gnt, mem_wen, mem_ren, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b0, 6'd3, 8'hA5}) begin
            n_fail++;
            $display("FAIL host_write got gnt=%b wen=%b ren=%b addr=%0h wdata=%0h need 1 1 0 3 a5",
                     h_gnt, mem_wen, mem_ren, mem_addr, mem_wdata);
        end
        tick();
        drive(0, 0, 0, '0, '0, 1, 0, 0, 6'd3, '0);
        settle();
        n_tests++;
        if ({e_gnt, h_gnt, mem_ren, mem_addr} !== {1'b1, 1'b0, 1'b1, 6'd3}) begin
            n_fail++;
            $display("FAIL engine_read_grant got e=%b h=%b ren=%b addr=%0h need 1 0 1 3",
                     e_gnt, h_gnt, mem_ren, mem_addr);
        end
        tick();
        idle_inputs();
        settle();
        n_tests++;
        if ({e_rvalid, h_rvalid, rdata} !== {1'b1, 1'b0, 8'hA5}) begin
            n_fail++;
            $display("FAIL engine_read_data got erv=%b hrv=%b rdata=%0h need 1 0 a5",
                     e_rvalid, h_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        drive(1, 0, 0, 6'd4, '0, 1, 0, 0, 6'd5, '0);
        for (int i = 0; i < 4; i++) begin
            settle();
            n_tests++;
            if ({h_gnt, e_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d got h/e=%b%b need %s", i, h_gnt, e_gnt,
                         (i % 2 == 0) ? "10" : "01");
            end
            if (i > 0) begin
                n_tests++;
                if ({h_rvalid, e_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rr_rvalid cycle %0d got h/e=%b%b", i, h_rvalid, e_rvalid);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_burst_limit();
        do_reset();
        drive(1, 0, 1, 6'd6, '0, 1, 0, 0, 6'd7, '0);
        for (int i = 0; i < 5; i++) begin
            settle();
            n_tests++;
            if ({h_gnt, e_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL burst_limit cycle %0d got h/e=%b%b need %s", i, h_gnt, e_gnt,
                         (i < 4) ? "10" : "01");
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_burst_saturate();
        int hcnt;
        do_reset();
        hcnt = 0;
        drive(1, 1, 1, 6'd8, 8'h11, 0, 0, 0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            settle();
            if (h_gnt === 1'b1 && e_gnt === 1'b0) hcnt++;
            tick();
        end
        n_tests++;
        if (hcnt != 10) begin
            n_fail++;
            $display("FAIL saturate_host_grants got %0d need 10", hcnt);
        end
        n_tests++;
        if (dut.r_bcnt !== 8'd4) begin
            n_fail++;
            $display("FAIL saturate_bcnt got %0d need 4", dut.r_bcnt);
        end
        e_req = 1'b1; e_we = 1'b0; e_addr = 6'd8;
        settle();
        n_tests++;
        if ({h_gnt, e_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL saturate_handover got h/e=%b%b need 01", h_gnt, e_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        drive(1, 0, 0, 6'd5, '0, 0, 0, 0, '0, '0);
        settle();
        n_tests++;
        if (h_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_grant got %b need 1", h_gnt);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({h_gnt, e_gnt, mem_wen, mem_ren, h_rvalid, e_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs got %b need 000000",
                     {h_gnt, e_gnt, mem_wen, mem_ren, h_rvalid, e_rvalid});
        end
        tick();
        n_tests++;
        if ({h_gnt, e_gnt, h_rvalid, e_rvalid} !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_hold got %b need 0000", {h_gnt, e_gnt, h_rvalid, e_rvalid});
        end
        idle_inputs();
        rst_n = 1'b1;
        settle();
        n_tests++;
        if ({h_rvalid, e_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_no_rvalid got %b%b need 00", h_rvalid, e_rvalid);
        end
        tick();
        drive(1, 0, 0, 6'd1, '0, 1, 0, 0, 6'd2, '0);
        settle();
        n_tests++;
        if ({h_gnt, e_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_first_grant got h/e=%b%b need 10", h_gnt, e_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        bit            gh, ge;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic          xw, xr;
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  AW'($urandom_range(0, 7)), DW'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  AW'($urandom_range(0, 7)), DW'($urandom));
            model_predict(gh, ge);
            xa = '0; xd = '0; xw = 1'b0; xr = 1'b0;
            if (gh)      begin xa = h_addr; xd = h_wdata; xw = h_we; xr = !h_we; end
            else if (ge) begin xa = e_addr; xd = e_wdata; xw = e_we; xr = !e_we; end
            settle();
            n_tests++;
            if ({h_gnt, e_gnt, mem_wen, mem_ren, mem_addr, mem_wdata} !== {gh, ge, xw, xr, xa, xd}) begin
                n_fail++;
                $display("FAIL rand_port c=%0d got g=%b%b w/r=%b%b a=%0h d=%0h need g=%b%b w/r=%b%b a=%0h d=%0h",
                         c, h_gnt, e_gnt, mem_wen, mem_ren, mem_addr, mem_wdata,
                         gh, ge, xw, xr, xa, xd);
            end
            n_tests++;
            if ({h_rvalid, e_rvalid} !== {m_hrv, m_erv}) begin
                n_fail++;
                $display("FAIL rand_rvalid c=%0d got %b%b need %b%b", c, h_rvalid, e_rvalid, m_hrv, m_erv);
            end
            if ((m_hrv || m_erv) && m_rexpv) begin
                n_tests++;
                if (rdata !== m_rexp) begin
                    n_fail++;
                    $display("FAIL rand_rdata c=%0d got %0h need %0h", c, rdata, m_rexp);
                end
            end
            model_commit(gh, ge);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst_limit();
        test_burst_saturate();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
